// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I/D block fills and D-side write-through stores onto one pipelined memory.
// Optional fill statistics counters are enabled with `define MEM_ARB_STATS_EN.
module mem_arbiter #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LAT         = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_miss,
    input  logic [ADDR_W-1:0]                  i_miss_addr,
    input  logic                               d_miss,
    input  logic [ADDR_W-1:0]                  d_miss_addr,
    input  logic                               d_wr_req,
    input  logic [ADDR_W-1:0]                  d_wr_addr,
    input  logic [DATA_W-1:0]                  d_wr_data,
    output logic                               mem_en,
    output logic                               mem_wr,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W-1:0]                  mem_wdata,
    input  logic [DATA_W-1:0]                  mem_rdata,
    input  logic                               mem_rvalid,
    output logic [DATA_W-1:0]                  fill_data,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
    output logic                               i_fill_we,
    output logic                               d_fill_we,
    output logic                               i_fill_done,
    output logic                               d_fill_done,
    output logic                               d_wr_done,
    output logic [15:0]                        i_fill_cnt,
    output logic [15:0]                        d_fill_cnt
);

    localparam int WB     = $clog2(WORDS_PER_BLOCK);
    localparam int BB     = $clog2(DATA_W / 8);
    localparam int OFF    = WB + BB;
    localparam int BASE_W = ADDR_W - OFF;
    localparam int CNT_W  = WB + 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FILL_D,
        FILL_I
    } state_t;

    state_t              state_q, state_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    issue_q, issue_d;
    logic [WB-1:0]       recv_q, recv_d;

    logic filling;
    logic issuing;
    logic accept;
    logic last;

    assign filling = (state_q == FILL_D) || (state_q == FILL_I);
    assign issuing = filling && !issue_q[WB];
    // A response is only taken while a read is outstanding, so strays cannot skew the word index.
    assign accept  = filling && mem_rvalid && (issue_q > {1'b0, recv_q});
    assign last    = accept && (recv_q == WB'(WORDS_PER_BLOCK - 1));

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        issue_d = issue_q;
        recv_d  = recv_q;
        case (state_q)
            IDLE: begin
                if (d_wr_req) begin
                    state_d = WRITE;
                    waddr_d = d_wr_addr;
                    wdata_d = d_wr_data;
                end else if (d_miss) begin
                    state_d = FILL_D;
                    base_d  = d_miss_addr[ADDR_W-1:OFF];
                end else if (i_miss) begin
                    state_d = FILL_I;
                    base_d  = i_miss_addr[ADDR_W-1:OFF];
                end
            end
            WRITE: state_d = IDLE;
            default: begin
                if (issuing) issue_d = issue_q + 1'b1;
                if (accept)  recv_d  = recv_q + 1'b1;
                if (last) begin
                    state_d = IDLE;
                    issue_d = '0;
                    recv_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            issue_q <= '0;
            recv_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            issue_q <= issue_d;
            recv_q  <= recv_d;
        end
    end

    always_comb begin
        mem_en    = (state_q == WRITE) || issuing;
        mem_wr    = (state_q == WRITE);
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == WRITE) begin
            mem_addr  = waddr_q;
            mem_wdata = wdata_q;
        end else if (issuing) begin
            mem_addr = {base_q, issue_q[WB-1:0], {BB{1'b0}}};
        end
    end

    assign fill_data   = mem_rdata;
    assign fill_word   = accept ? recv_q : '0;
    assign i_fill_we   = accept && (state_q == FILL_I);
    assign d_fill_we   = accept && (state_q == FILL_D);
    assign i_fill_done = last && (state_q == FILL_I);
    assign d_fill_done = last && (state_q == FILL_D);
    assign d_wr_done   = (state_q == WRITE);

`ifdef MEM_ARB_STATS_EN
    logic [15:0] icnt_q;
    logic [15:0] dcnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icnt_q <= '0;
            dcnt_q <= '0;
        end else begin
            if (i_fill_done && (icnt_q != 16'hFFFF)) icnt_q <= icnt_q + 16'd1;
            if (d_fill_done && (dcnt_q != 16'hFFFF)) dcnt_q <= dcnt_q + 16'd1;
        end
    end

    assign i_fill_cnt = icnt_q;
    assign d_fill_cnt = dcnt_q;
`else
    assign i_fill_cnt = '0;
    assign d_fill_cnt = '0;
`endif

    // Block-offset address bits are dropped by design; latency is the memory's concern.
    logic unused_ok;
    assign unused_ok = ^{i_miss_addr[OFF-1:0], d_miss_addr[OFF-1:0]} ^ (MEM_LAT == 0);

endmodule
